mem_arbiter: RTL and testbench



---
 rtl/dirv_mem_pkg.sv | 7 +
 rtl/mem_rr_pick.sv | 9 +
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dirv_mem_pkg.sv
// dirv_mem_pkg: shared state, port and command encodings for the memory arbiter
package dirv_mem_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_DONE, S_ERR} state_t;
  typedef enum logic {IMEM = 1'b0, DMEM = 1'b1} port_t;
  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;
endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: round-robin choice between the imem and dmem requesters
module mem_rr_pick import dirv_mem_pkg::*; (
  input  logic  imem_req,
  input  logic  dmem_req,
  input  port_t last_grant,
  output port_t grant
);
  always_comb grant = (dmem_req && !(imem_req && last_grant == DMEM)) ? DMEM : IMEM;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving imem/dmem single-outstanding access to one memory port
module mem_arbiter import dirv_mem_pkg::*; #(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8,
  parameter int p_MEM_BYTES = 262144
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [p_ADDR_BITS-1:0] imem_addr,
  input  logic                   imem_cmd,
  input  logic                   imem_req,
  output logic                   imem_resp,
  output logic                   imem_r_rddv,
  output logic [p_DATA_BITS-1:0] imem_r_data,
  output logic                   imem_w_ack,
  input  logic [p_STRB_BITS-1:0] imem_w_strb,
  input  logic [p_DATA_BITS-1:0] imem_w_data,
  input  logic [p_ADDR_BITS-1:0] dmem_addr,
  input  logic                   dmem_cmd,
  input  logic                   dmem_req,
  output logic                   dmem_resp,
  output logic                   dmem_r_rddv,
  output logic [p_DATA_BITS-1:0] dmem_r_data,
  output logic                   dmem_w_ack,
  input  logic [p_STRB_BITS-1:0] dmem_w_strb,
  input  logic [p_DATA_BITS-1:0] dmem_w_data,
  output logic                   mem_req,
  output logic                   mem_cmd,
  output logic [p_ADDR_BITS-1:0] mem_addr,
  output logic [p_STRB_BITS-1:0] mem_strb,
  output logic [p_DATA_BITS-1:0] mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [p_DATA_BITS-1:0] mem_rdata
);
  localparam logic [p_ADDR_BITS:0] MEM_LIMIT = (p_ADDR_BITS+1)'(p_MEM_BYTES);
  state_t state, state_nx;
  port_t last_grant, pick, port_q;
  logic cmd_q, any_req, fin, rd_done;
  logic [p_ADDR_BITS-1:0] addr_q, sel_addr;
  logic [p_STRB_BITS-1:0] strb_q;
  logic [p_DATA_BITS-1:0] wdata_q, rdata_q;
  mem_rr_pick u_pick (
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .last_grant(last_grant),
    .grant     (pick)
  );
  assign any_req  = imem_req | dmem_req;
  assign sel_addr = pick == DMEM ? dmem_addr : imem_addr;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = !any_req ? S_IDLE : {1'b0, sel_addr} >= MEM_LIMIT ? S_ERR : S_ISSUE;
      S_ISSUE:  state_nx = !mem_gnt ? S_ISSUE : cmd_q == CMD_WR ? S_DONE : S_RDWAIT;
      S_RDWAIT: state_nx = mem_rvalid ? S_DONE : S_RDWAIT;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= IMEM;
      port_q     <= IMEM;
      cmd_q      <= CMD_RD;
      addr_q     <= '0;
      strb_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && any_req) begin
        port_q  <= pick;
        cmd_q   <= pick == DMEM ? dmem_cmd : imem_cmd;
        addr_q  <= sel_addr;
        strb_q  <= pick == DMEM ? dmem_w_strb : imem_w_strb;
        wdata_q <= pick == DMEM ? dmem_w_data : imem_w_data;
      end
      if (state == S_RDWAIT && mem_rvalid) rdata_q <= mem_rdata;
      if (fin) last_grant <= port_q;
    end
  // Completion outputs are pure decodes of state and captured registers
  assign fin         = state == S_DONE || state == S_ERR;
  assign rd_done     = state == S_DONE && cmd_q == CMD_RD;
  assign imem_resp   = state == S_ERR && port_q == IMEM;
  assign imem_r_rddv = fin && port_q == IMEM && cmd_q == CMD_RD;
  assign imem_w_ack  = fin && port_q == IMEM && cmd_q == CMD_WR;
  assign imem_r_data = rd_done && port_q == IMEM ? rdata_q : '0;
  assign dmem_resp   = state == S_ERR && port_q == DMEM;
  assign dmem_r_rddv = fin && port_q == DMEM && cmd_q == CMD_RD;
  assign dmem_w_ack  = fin && port_q == DMEM && cmd_q == CMD_WR;
  assign dmem_r_data = rd_done && port_q == DMEM ? rdata_q : '0;
  assign mem_req     = state == S_ISSUE;
  assign mem_cmd     = cmd_q;
  assign mem_addr    = addr_q;
  assign mem_strb    = strb_q;
  assign mem_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for the two-port memory arbiter
module tb_mem_arbiter;
  import dirv_mem_pkg::*;
  typedef struct { logic port; logic wr; logic [31:0] data; logic resp; int t0; int lat; } done_t;
  typedef struct { logic wr; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } acc_t;
  logic clk = 0, rst_n = 0;
  logic [31:0] imem_addr = 0, imem_r_data, imem_w_data = 0;
  logic [31:0] dmem_addr = 0, dmem_r_data, dmem_w_data = 0;
  logic imem_cmd = 0, imem_req = 0, imem_resp, imem_r_rddv, imem_w_ack;
  logic dmem_cmd = 0, dmem_req = 0, dmem_resp, dmem_r_rddv, dmem_w_ack;
  logic [3:0] imem_w_strb = 0, dmem_w_strb = 0, mem_strb;
  logic mem_req, mem_cmd, mem_gnt = 1, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  done_t exp_q[$];
  acc_t mem_q[$];
  int vectors = 0, miscompares = 0, cyc = 0, dmem_reload = 0;
  logic rv_en = 1, rv_pend = 0;
  logic [31:0] rv_data = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_cmd(imem_cmd), .imem_req(imem_req), .imem_resp(imem_resp),
    .imem_r_rddv(imem_r_rddv), .imem_r_data(imem_r_data), .imem_w_ack(imem_w_ack),
    .imem_w_strb(imem_w_strb), .imem_w_data(imem_w_data),
    .dmem_addr(dmem_addr), .dmem_cmd(dmem_cmd), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .dmem_r_rddv(dmem_r_rddv), .dmem_r_data(dmem_r_data), .dmem_w_ack(dmem_w_ack),
    .dmem_w_strb(dmem_w_strb), .dmem_w_data(dmem_w_data),
    .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [139:0] outs();
    return {imem_resp, imem_r_rddv, imem_r_data, imem_w_ack, dmem_resp, dmem_r_rddv, dmem_r_data,
            dmem_w_ack, mem_req, mem_cmd, mem_addr, mem_strb, mem_wdata};
  endfunction

  // Drive a request and push its expected memory access and completion
  task automatic issue(input logic p, input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] data, input int lat, input bit track);
    logic oor;
    acc_t a;
    done_t e;
    oor = addr >= 32'h0004_0000;
    if (p) begin
      dmem_cmd = wr; dmem_addr = addr; dmem_w_strb = strb; dmem_w_data = data; dmem_req = 1;
    end else begin
      imem_cmd = wr; imem_addr = addr; imem_w_strb = strb; imem_w_data = data; imem_req = 1;
    end
    if (!oor) begin
      a = '{wr, addr, wr ? strb : 4'h0, wr ? data : 32'h0};
      mem_q.push_back(a);
    end
    if (track) begin
      e = '{p, wr, (oor || wr) ? 32'h0 : mem_model(addr), oor, cyc, lat};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0 || dmem_reload != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || mem_q.size() != 0 || dmem_reload != 0) begin
      vectors++; miscompares++;
      $display("FAIL timeout: %0d completions and %0d accesses still pending", exp_q.size(), mem_q.size());
      exp_q.delete(); mem_q.delete(); dmem_reload = 0;
      imem_req = 0; dmem_req = 0; rst_n = 0;
      @(negedge clk) rst_n = 1;
    end
    repeat (2) @(negedge clk);
  endtask

  // Memory responder and completion scoreboard, evaluated just after each falling edge
  initial begin : monitor
    done_t e;
    acc_t a;
    logic [69:0] got, want;
    logic [34:0] side;
    forever begin
      @(negedge clk);
      #1;
      if (rv_en) begin
        mem_rvalid = rv_pend;
        mem_rdata  = rv_pend ? rv_data : 32'h0;
        rv_pend    = 0;
      end
      if (mem_req && mem_gnt) begin
        vectors++;
        if (mem_q.size() == 0) begin
          miscompares++;
          $display("FAIL mem_access: unexpected cmd=%0d addr=%h", mem_cmd, mem_addr);
        end else begin
          a = mem_q.pop_front();
          if ({mem_cmd, mem_addr, mem_cmd ? mem_strb : 4'h0, mem_cmd ? mem_wdata : 32'h0} !== {a.wr, a.addr, a.strb, a.wdata}) begin
            miscompares++;
            $display("FAIL mem_access: got cmd=%0d addr=%h strb=%h wdata=%h, want cmd=%0d addr=%h strb=%h wdata=%h",
                     mem_cmd, mem_addr, mem_strb, mem_wdata, a.wr, a.addr, a.strb, a.wdata);
          end
        end
        if (rv_en && mem_cmd == CMD_RD) begin
          rv_pend = 1;
          rv_data = mem_model(mem_addr);
        end
      end
      if ((!imem_r_rddv && imem_r_data !== 0) || (!dmem_r_rddv && dmem_r_data !== 0)) begin
        miscompares++;
        $display("FAIL r_data_idle: imem=%h dmem=%h, want 0", imem_r_data, dmem_r_data);
      end
      if (imem_r_rddv | imem_w_ack | imem_resp | dmem_r_rddv | dmem_w_ack | dmem_resp) begin
        vectors++;
        got = {imem_r_rddv, imem_w_ack, imem_resp, imem_r_data, dmem_r_rddv, dmem_w_ack, dmem_resp, dmem_r_data};
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse: got %h, want none", got);
        end else begin
          e = exp_q.pop_front();
          side = {!e.wr, e.wr, e.resp, e.wr ? 32'h0 : e.data};
          want = e.port ? {35'h0, side} : {side, 35'h0};
          if (got !== want) begin
            miscompares++;
            $display("FAIL completion: got %h, want %h", got, want);
          end
          if (e.lat >= 0) begin
            vectors++;
            if (cyc - e.t0 != e.lat) begin
              miscompares++;
              $display("FAIL latency: got %0d cycles, want %0d", cyc - e.t0, e.lat);
            end
          end
        end
        if (imem_r_rddv | imem_w_ack | imem_resp) imem_req = 0;
        if (dmem_r_rddv | dmem_w_ack | dmem_resp) begin
          dmem_req = 0;
          if (dmem_reload > 0) begin
            dmem_reload--;
            issue(1'b1, CMD_RD, 32'h204, 4'h0, 32'h0, -1, 1);
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (outs() !== 0) begin miscompares++; $display("FAIL reset_outputs: got %h, want 0", outs()); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if (outs() !== 0) begin miscompares++; $display("FAIL idle_outputs: got %h, want 0", outs()); end
  endtask

  task automatic test_dmem_read;
    mem_gnt = 1;
    @(negedge clk) issue(1'b1, CMD_RD, 32'h100, 4'h0, 32'h0, 3, 1);
    wait_idle(50);
    @(negedge clk) issue(1'b1, CMD_RD, 32'h3FFFC, 4'h0, 32'h0, 3, 1);
    wait_idle(50);
  endtask

  task automatic test_tie;
    rst_n = 0;
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      issue(1'b1, CMD_RD, 32'h1000 + 32'(r * 8), 4'h0, 32'h0, 3, 1);
      issue(1'b0, CMD_RD, 32'h2000 + 32'(r * 8), 4'h0, 32'h0, 7, 1);
      wait_idle(60);
    end
  endtask

  task automatic test_write_stall;
    mem_gnt = 0;
    @(negedge clk) issue(1'b0, CMD_WR, 32'h40, 4'b0011, 32'h1234_5678, 7, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({mem_req, mem_cmd, mem_addr, mem_strb, mem_wdata} !== {1'b1, CMD_WR, 32'h40, 4'b0011, 32'h1234_5678}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got req=%0d cmd=%0d addr=%h strb=%h wdata=%h, want 1 1 00000040 3 12345678",
                 i, mem_req, mem_cmd, mem_addr, mem_strb, mem_wdata);
      end
      if (i == 5) mem_gnt = 1;
    end
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0) begin miscompares++; $display("FAIL stall_release: got mem_req=%0d, want 0", mem_req); end
    wait_idle(50);
  endtask

  task automatic test_out_of_range;
    mem_gnt = 1;
    @(negedge clk) issue(1'b1, CMD_RD, 32'h0004_0000, 4'h0, 32'h0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (mem_req !== 1'b0) begin miscompares++; $display("FAIL oor_no_access: got mem_req=%0d, want 0", mem_req); end
    end
    wait_idle(50);
    @(negedge clk) issue(1'b0, CMD_WR, 32'hFFFF_FFFC, 4'hF, 32'hCAFE_F00D, 1, 1);
    wait_idle(50);
  endtask

  task automatic test_reset_mid;
    rv_en = 0;
    mem_gnt = 1;
    @(negedge clk) issue(1'b1, CMD_RD, 32'h180, 4'h0, 32'h0, -1, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    dmem_req = 0;
    #1;
    vectors++;
    if (outs() !== 0) begin miscompares++; $display("FAIL reset_mid_outputs: got %h, want 0", outs()); end
    @(negedge clk) rst_n = 1;
    @(negedge clk) begin mem_rvalid = 1; mem_rdata = 32'h5555_AAAA; end
    @(negedge clk) begin mem_rvalid = 0; mem_rdata = 32'h0; end
    repeat (3) @(negedge clk);
    vectors++;
    if (outs() !== 0) begin miscompares++; $display("FAIL late_rvalid_outputs: got %h, want 0", outs()); end
    rv_en = 1;
    @(negedge clk) issue(1'b1, CMD_RD, 32'h184, 4'h0, 32'h0, 3, 1);
    wait_idle(50);
  endtask

  task automatic test_no_starve;
    mem_gnt = 1;
    @(negedge clk) begin dmem_reload = 1; issue(1'b1, CMD_RD, 32'h200, 4'h0, 32'h0, -1, 1); end
    @(negedge clk) issue(1'b0, CMD_RD, 32'h300, 4'h0, 32'h0, -1, 1);
    wait_idle(100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dmem_read();
    test_tie();
    test_write_stall();
    test_out_of_range();
    test_reset_mid();
    test_no_starve();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
